seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Reader side of the 7-segment display interface: samples the multiplexed anode/segment
//  lines driven by the display scanner and recovers the hex value being shown. Used as an
//  on-chip self-check/debug monitor (compare against the value the core intended to display)
//  and as a bench-side checker. Inverts the team hex->segment code; flags illegal patterns.
// PARAMETERS
//  DIGITS         8   number of multiplexed digits (anode lines), 1..8
//  STABLE_CYCLES  4   synced cycles {an,seg} must hold unchanged before capture, >=1
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  an           in   DIGITS     anode enables, active-low, one-hot when a digit is lit
//  seg          in   7          segments {a,b,c,d,e,f,g}, seg[6]=a .. seg[0]=g, active-low
//  value        out  4*DIGITS   live decoded value, digit i -> value[4i+3:4i]
//  digit_valid  out  DIGITS     bit i set = digit i holds a legally decoded nibble
//  frame_value  out  4*DIGITS   snapshot of value at last complete frame
//  frame_valid  out  1          1-cycle pulse: every digit captured since last frame
//  err          out  1          1-cycle pulse: illegal anode or segment pattern captured
// BEHAVIOUR
//  Reset: value, digit_valid, frame_value, seen mask = 0; frame_valid, err = 0; FSM=IDLE.
//  Input sync: an and seg each pass a 2-FF synchroniser; all logic uses synced copies.
//  Decode table (seg -> nibble): 0000001->0 1001111->1 0010010->2 0000110->3 1001100->4
//   0100100->5 0100000->6 0001111->7 0000000->8 0001100->9 0001000->A 1100000->B
//   1110010->C 1000010->D 0110000->E 0111000->F; any other code is illegal.
//  FSM (on synced {an,seg}; "change" = differs from previous synced cycle):
//   IDLE    : an all-ones (blanking). Non-blank -> WAIT, cnt=1.
//   WAIT    : change -> cnt=1 (stay WAIT, or IDLE if blank); else cnt++; cnt==STABLE_CYCLES
//             -> CAPTURE action this cycle, go HOLD. cnt saturates, width clog2(STABLE_CYCLES+1).
//   HOLD    : one capture per stable period; change -> WAIT cnt=1 (IDLE if blank).
//  Capture action (registered, single cycle):
//   - an has >1 low bit: err=1; no digit updated.
//   - an one-hot at index i, seg legal: value nibble i <= decode; digit_valid[i]<=1; seen[i]<=1.
//   - an one-hot at index i, seg illegal: err=1; nibble i unchanged; digit_valid[i]<=0;
//     seen[i] not set.
//  Latency: a change of {an,seg} applied at edge k, held, updates value at edge
//   k+2+STABLE_CYCLES (2 sync + stability count).
//  Frame: when seen (including the current capture) becomes all-ones: frame_value <= new
//   value (including current capture), frame_valid=1 for that cycle, seen <= 0 same cycle.
//  Same digit captured twice before frame complete: overwrite, no error.
//  Held pattern never re-captures; repeated identical scan revisits re-capture normally.
//  rst_n low at any time (mid-count, mid-frame): immediate return to reset state; sync FFs
//   cleared to blank (an=all-ones, seg=all-ones); no pulse emitted on release.
//  err and frame_valid may pulse in the same cycle only when both conditions hold.
// TESTING (DIGITS=8, STABLE_CYCLES=4)
//  1 Scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 10 clk -> one frame_valid pulse,
//    frame_value=32'h87654321, digit_valid=8'hFF, err never set.
//  2 Digit 0 seg=0000110 held 5 clk then blank -> value[3:0]=3 at edge k+6; held only
//    3 clk -> no capture, value unchanged.
//  3 Digit 2 seg=1111111 held 10 clk -> single err pulse, digit_valid[2]=0, value[11:8] kept.
//  4 an=8'b11111100 with legal seg held 10 clk -> single err pulse, value/digit_valid unchanged.
//  5 Digit 0 cycled through all 16 table codes -> value[3:0] = 0..F in order, no err.
//  6 Capture digits 0..3, pulse rst_n low 1 clk, then full scan 8..F -> all outputs 0 during
//    reset; exactly one frame_valid afterwards, frame_value=32'hFEDCBA98.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display scan lines plus decoded monitor results.
// master = display/scanner side, slave = the decoder.
interface seg_scan_decoder_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_valid;
    logic [4*DIGITS-1:0] frame_value;
    logic                frame_valid;
    logic                err;

    modport master (
        output an,
        output seg,
        input  value,
        input  digit_valid,
        input  frame_value,
        input  frame_valid,
        input  err
    );

    modport slave (
        input  an,
        input  seg,
        output value,
        output digit_valid,
        output frame_value,
        output frame_valid,
        output err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples multiplexed anode/segment lines and recovers
// the displayed hex digits, flagging illegal anode or segment patterns.
module seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    logic [DIGITS-1:0] an_m_q, an_s_q, an_p_q;
    logic [6:0]        seg_m_q, seg_s_q, seg_p_q;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cap;

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   dv_q, dv_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] fval_q, fval_d;
    logic                fvld_q, fvld_d;
    logic                err_q, err_d;

    logic              blank;
    logic              change;
    logic [DIGITS-1:0] anl;
    logic              multi;
    logic [4:0]        dec;
    logic [DIGITS-1:0] seen_nx;

    // Returns {legal, nibble} for an active-low segment code.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = 5'h10;
            7'b1001111: r = 5'h11;
            7'b0010010: r = 5'h12;
            7'b0000110: r = 5'h13;
            7'b1001100: r = 5'h14;
            7'b0100100: r = 5'h15;
            7'b0100000: r = 5'h16;
            7'b0001111: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0001100: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b1100000: r = 5'h1B;
            7'b1110010: r = 5'h1C;
            7'b1000010: r = 5'h1D;
            7'b0110000: r = 5'h1E;
            7'b0111000: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Two-stage synchroniser plus previous-cycle copy for change detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m_q  <= '1;
            an_s_q  <= '1;
            an_p_q  <= '1;
            seg_m_q <= '1;
            seg_s_q <= '1;
            seg_p_q <= '1;
        end else begin
            an_m_q  <= bus.an;
            an_s_q  <= an_m_q;
            an_p_q  <= an_s_q;
            seg_m_q <= bus.seg;
            seg_s_q <= seg_m_q;
            seg_p_q <= seg_s_q;
        end
    end

    assign blank  = &an_s_q;
    assign change = {an_s_q, seg_s_q} != {an_p_q, seg_p_q};

    // Stability FSM: one capture after the pattern holds long enough.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!blank) begin
                    state_d = WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT: begin
                if (change) begin
                    cnt_d   = CNT_ONE;
                    state_d = blank ? IDLE : WAIT;
                end else if (cnt_q == CNT_MAX) begin
                    cap     = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (change) begin
                    cnt_d   = CNT_ONE;
                    state_d = blank ? IDLE : WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign anl   = ~an_s_q;
    assign multi = (anl & (anl - 1'b1)) != '0;
    assign dec   = decode(seg_s_q);

    // Capture datapath: update one digit, track frame completion.
    always_comb begin
        value_d = value_q;
        dv_d    = dv_q;
        seen_d  = seen_q;
        fval_d  = fval_q;
        fvld_d  = 1'b0;
        err_d   = 1'b0;
        seen_nx = seen_q | anl;
        if (cap) begin
            if (multi || (anl == '0)) begin
                err_d = 1'b1;
            end else if (!dec[4]) begin
                err_d = 1'b1;
                dv_d  = dv_q & ~anl;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (anl[i]) begin
                        value_d[4*i +: 4] = dec[3:0];
                    end
                end
                dv_d = dv_q | anl;
                if (&seen_nx) begin
                    fval_d = value_d;
                    fvld_d = 1'b1;
                    seen_d = '0;
                end else begin
                    seen_d = seen_nx;
                end
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            dv_q    <= '0;
            seen_q  <= '0;
            fval_q  <= '0;
            fvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            dv_q    <= dv_d;
            seen_q  <= seen_d;
            fval_q  <= fval_d;
            fvld_q  <= fvld_d;
            err_q   <= err_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_valid = dv_q;
    assign bus.frame_value = fval_q;
    assign bus.frame_valid = fvld_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans plus random scan traffic checked
// every cycle against a run-length based reference model.
module tb_seg_scan_decoder;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    seg_scan_decoder_if #(.DIGITS(8)) bus();

    seg_scan_decoder #(.DIGITS(8), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_value, m_fvv;
    logic [7:0]  m_dv, m_seen;
    logic        m_fv, m_err;
    logic [14:0] prev, pa_p, pb_p;
    bit          pa_v, pb_v;
    int          run;

    function automatic logic [6:0] code(input int n);
        case (n)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0001100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b1110010;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_value = '0;
        m_dv    = '0;
        m_fvv   = '0;
        m_fv    = 1'b0;
        m_err   = 1'b0;
        m_seen  = '0;
        prev    = {8'hFF, 7'h7F};
        run     = 1;
        pa_v    = 1'b0;
        pb_v    = 1'b0;
        pa_p    = '0;
        pb_p    = '0;
    endtask

    task automatic model_capture(input logic [14:0] p);
        logic [7:0] a;
        int zeros, idx, nib;
        a = p[14:7];
        zeros = 0;
        idx = 0;
        nib = -1;
        for (int i = 0; i < 8; i++) begin
            if (!a[i]) begin
                zeros++;
                idx = i;
            end
        end
        for (int n = 0; n < 16; n++) begin
            if (code(n) == p[6:0]) nib = n;
        end
        if (zeros != 1) begin
            m_err = 1'b1;
        end else if (nib < 0) begin
            m_err = 1'b1;
            m_dv[idx] = 1'b0;
        end else begin
            m_value[4*idx +: 4] = 4'(nib);
            m_dv[idx] = 1'b1;
            m_seen[idx] = 1'b1;
            if (m_seen == 8'hFF) begin
                m_fvv  = m_value;
                m_fv   = 1'b1;
                m_seen = '0;
            end
        end
    endtask

    // Called just after each rising edge with the inputs sampled there.
    task automatic step();
        logic [14:0] cur, act_p;
        bit act_v;
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            act_v = pa_v;
            act_p = pa_p;
            pa_v  = pb_v;
            pa_p  = pb_p;
            cur   = {bus.an, bus.seg};
            if (cur == prev) begin
                if (run < 1000) run++;
            end else begin
                run = 1;
            end
            prev = cur;
            pb_v = (run == S + 1) && (cur[14:7] != 8'hFF);
            pb_p = cur;
            if (act_v) model_capture(act_p);
        end
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) begin
            @(posedge clk);
            step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        bus.an  = 8'hFF;
        bus.seg = 7'h7F;
        @(posedge clk);
        step();
        @(negedge clk);
        chk("rst_value", bus.value, 32'h0);
        chk("rst_dv", 32'(bus.digit_valid), 32'h0);
        chk("rst_fval", bus.frame_value, 32'h0);
        chk("rst_pulses", 32'({bus.frame_valid, bus.err}), 32'h0);
        rst_n = 1'b1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("value", bus.value, m_value);
            chk("digit_valid", 32'(bus.digit_valid), 32'(m_dv));
            chk("frame_value", bus.frame_value, m_fvv);
            chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
            chk("err", 32'(bus.err), 32'(m_err));
            if (bus.frame_valid) fv_cnt++;
            if (bus.err) err_cnt++;
        end
    end

    initial begin
        int fv0, er0, r, hn;
        logic [31:0] v0;
        logic [7:0] d0, a;
        logic [6:0] s;
        bus.an  = 8'hFF;
        bus.seg = 7'h7F;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        hold(8'hFF, 7'h7F, 3);

        fv0 = fv_cnt;
        er0 = err_cnt;
        for (int d = 0; d < 8; d++) hold(~(8'd1 << d), code(d + 1), 10);
        hold(8'hFF, 7'h7F, 10);
        chk("t1_frames", 32'(fv_cnt - fv0), 32'd1);
        chk("t1_fval", bus.frame_value, 32'h87654321);
        chk("t1_dv", 32'(bus.digit_valid), 32'hFF);
        chk("t1_err", 32'(err_cnt - er0), 32'd0);

        hold(8'hFE, 7'b0000110, 5);
        chk("t2_k4", 32'(bus.value[3:0]), 32'h1);
        hold(8'hFF, 7'h7F, 1);
        chk("t2_k5", 32'(bus.value[3:0]), 32'h1);
        hold(8'hFF, 7'h7F, 1);
        chk("t2_k6", 32'(bus.value[3:0]), 32'h3);
        hold(8'hFF, 7'h7F, 8);
        hold(8'hFE, code(5), 3);
        hold(8'hFF, 7'h7F, 10);
        chk("t2_short", 32'(bus.value[3:0]), 32'h3);

        er0 = err_cnt;
        hold(8'hFB, 7'h7F, 10);
        hold(8'hFF, 7'h7F, 10);
        chk("t3_err", 32'(err_cnt - er0), 32'd1);
        chk("t3_dv2", 32'(bus.digit_valid[2]), 32'd0);
        chk("t3_val", 32'(bus.value[11:8]), 32'h3);

        er0 = err_cnt;
        v0 = bus.value;
        d0 = bus.digit_valid;
        hold(8'b11111100, code(9), 10);
        hold(8'hFF, 7'h7F, 10);
        chk("t4_err", 32'(err_cnt - er0), 32'd1);
        chk("t4_val", bus.value, v0);
        chk("t4_dv", 32'(bus.digit_valid), 32'(d0));

        er0 = err_cnt;
        for (int n = 0; n < 16; n++) begin
            hold(8'hFE, code(n), 8);
            chk("t5_nib", 32'(bus.value[3:0]), 32'(n));
        end
        hold(8'hFF, 7'h7F, 5);
        chk("t5_err", 32'(err_cnt - er0), 32'd0);

        for (int d = 0; d < 4; d++) hold(~(8'd1 << d), code(d + 1), 10);
        do_reset();
        fv0 = fv_cnt;
        hold(8'hFF, 7'h7F, 3);
        for (int d = 0; d < 8; d++) hold(~(8'd1 << d), code(d + 8), 10);
        hold(8'hFF, 7'h7F, 10);
        chk("t6_frames", 32'(fv_cnt - fv0), 32'd1);
        chk("t6_fval", bus.frame_value, 32'hFEDCBA98);

        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                a = 8'hFF;
            end else if (r == 1) begin
                a = ~((8'd1 << $urandom_range(0, 3)) |
                      (8'd1 << $urandom_range(4, 7)));
            end else begin
                a = ~(8'd1 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 99) < 85) s = code(int'($urandom_range(0, 15)));
            else s = 7'($urandom);
            hn = int'($urandom_range(1, 8));
            hold(a, s, hn);
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        hold(8'hFF, 7'h7F, 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
